// File: rtl/seg_display_arbiter_if.sv
// Bundle between the value producers and the display arbiter: requests and data in,
// current owner and its registered value out.
interface seg_display_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_data;
    logic [NUM_REQ-1:0]   o_grant;
    logic                 o_valid;
    logic [7:0]           o_value;
    logic                 o_switch;

    modport master (
        output i_req, i_data,
        input  o_grant, o_valid, o_value, o_switch
    );

    modport slave (
        input  i_req, i_data,
        output o_grant, o_valid, o_value, o_switch
    );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner selection for the two-digit seven-segment display, with a
// guaranteed minimum ownership time before another requester can take over.
module seg_display_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 25_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    seg_display_arbiter_if.slave  io_bus
);
    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_OPEN} state_t;

    state_t               r_state;
    logic [IW-1:0]        r_own;
    logic [IW-1:0]        r_ptr;
    logic [CW-1:0]        r_cnt;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_valid;
    logic [7:0]           r_value;
    logic                 r_switch;

    state_t               w_state_nxt;
    logic [IW-1:0]        w_own_nxt;
    logic [IW-1:0]        w_ptr_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 w_take;
    logic [IW-1:0]        w_cand;
    logic [NUM_REQ-1:0]   w_own_mask;
    logic                 w_any;
    logic                 w_others;
    logic                 w_own_req;

    // First requesting index at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [IW-1:0] f_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IW-1:0]      ptr);
        logic [IW-1:0] sel;
        logic [IW-1:0] idx;
        sel = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            idx = IW'((32'(ptr) + i - 1) % NUM_REQ);
            if (req[idx]) sel = idx;
        end
        return sel;
    endfunction

    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] j);
        if (32'(j) == NUM_REQ - 1) return '0;
        return j + IW'(1);
    endfunction

    assign w_own_mask = NUM_REQ'(1) << r_own;
    assign w_any      = |io_bus.i_req;
    assign w_others   = |(io_bus.i_req & ~w_own_mask);
    assign w_own_req  = io_bus.i_req[r_own];
    assign w_cand     = f_pick(io_bus.i_req, r_ptr);

    always_comb begin
        w_state_nxt = r_state;
        w_own_nxt   = r_own;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_take      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) w_take = 1'b1;
            end
            S_HOLD: begin
                if (!w_own_req) begin
                    if (w_any) w_take = 1'b1;
                    else       w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    // Last protected cycle already decides like OPEN, so a waiting
                    // competitor takes over exactly HOLD_CYCLES after the switch.
                    if (w_others) w_take = 1'b1;
                    else          w_state_nxt = S_OPEN;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_OPEN: begin
                if (w_others)       w_take = 1'b1;
                else if (!w_own_req) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_take) begin
            w_own_nxt   = w_cand;
            w_ptr_nxt   = f_next(w_cand);
            w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
            w_state_nxt = S_HOLD;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_own    <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_grant  <= '0;
            r_valid  <= 1'b0;
            r_value  <= '0;
            r_switch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_own    <= w_own_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_switch <= w_take;
            if (w_state_nxt == S_IDLE) begin
                r_grant <= '0;
                r_valid <= 1'b0;
                r_value <= '0;
            end else begin
                r_grant <= NUM_REQ'(1) << w_own_nxt;
                r_valid <= 1'b1;
                r_value <= io_bus.i_data[8*w_own_nxt +: 8];
            end
        end
    end

    assign io_bus.o_grant  = r_grant;
    assign io_bus.o_valid  = r_valid;
    assign io_bus.o_value  = r_value;
    assign io_bus.o_switch = r_switch;
endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Shares the board's two-digit seven-segment display among several requesters (up/down counter, switch monitor, status codes) that each want to show an 8-bit value. Arbitration is round-robin. Each new owner keeps the display for a guaranteed minimum time before it can be preempted. The block sits between the value producers and the two nibble decoders: `o_value[7:4]` drives digit 1 and `o_value[3:0]` drives digit 2.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `HOLD_CYCLES`, default 25_000_000: minimum ownership in clock cycles (1 s at 25 MHz). Must be ≥ 1.

Ports:
- `i_clk`, in, 1: system clock.
- `i_reset`, in, 1: reset, asynchronous, active-high.
- `i_req`, in, `NUM_REQ`: level request per requester. Held high while the requester wants the display.
- `i_data`, in, `8*NUM_REQ`: value of requester k on bits `[8k+7:8k]`.
- `o_grant`, out, `NUM_REQ`: one-hot current owner. All zero when idle.
- `o_valid`, out, 1: high while the display has an owner.
- `o_value`, out, 8: registered value of the owner. Consumers blank the display when `o_valid` = 0.
- `o_switch`, out, 1: one-cycle pulse in the first cycle of every new ownership.

## Operation
- State: FSM {IDLE, HOLD, OPEN}, owner index `own`, round-robin pointer `ptr`, hold counter `cnt` of width `$clog2(HOLD_CYCLES+1)`.
- Candidate selection: the first index with `i_req` high, searching `ptr`, `ptr+1`, … modulo `NUM_REQ`.
- On any grant to index j:
  - `own` ← j, `ptr` ← (j+1) mod `NUM_REQ`, `cnt` ← `HOLD_CYCLES-1`.
  - `o_switch` pulses; the next state is HOLD.
- IDLE:
  - `o_grant` = 0, `o_valid` = 0, `o_value` = 0x00.
  - Any `i_req` high: grant the candidate.
- HOLD (owner protected):
  - `cnt` decrements every cycle.
  - Other requests are ignored.
  - Owner drops `i_req`: release at once. If another request is high, grant the candidate (no idle cycle in between). Otherwise go to IDLE.
  - `cnt` = 0 with the owner still requesting: go to OPEN.
- OPEN (hold expired):
  - Any other `i_req` high: grant the candidate. The search starts at `ptr`, so the current owner is considered last.
  - No other request and the owner still requesting: stay in OPEN, with no `o_switch` pulse.
  - Owner drops `i_req` and no other request: go to IDLE.
- `o_value` ← `i_data[own_next]` on every clock while an owner exists. The register tracks live changes in the owner's data.
- Simultaneous events:
  - Owner release and hold expiry in the same cycle: release wins.
  - Several new requests at once: the round-robin order decides.
- `ptr` wraps from `NUM_REQ-1` to 0.
- The `cnt` underflow path is unreachable. The counter saturates at 0 in OPEN.

## Timing
- All outputs are registered.
- Reset values, asserted asynchronously and held while `i_reset` = 1:
  - `o_grant` = 0, `o_valid` = 0, `o_value` = 0x00, `o_switch` = 0.
  - State IDLE, `ptr` = 0, `cnt` = 0.
- Reset mid-operation drops ownership immediately. There is no `o_switch` pulse on reset or on its release.
- Grant latency: `i_req` rising in cycle n, with the block idle, gives `o_grant`/`o_valid`/`o_switch` high in cycle n+1.
  - `o_value` in n+1 equals `i_data` of the owner sampled at the edge that ends cycle n.
- Data latency: 1 cycle from `i_data` to `o_value`.
- Release latency: owner `i_req` low in cycle n gives the new grant, or `o_valid` = 0, in cycle n+1.
- Minimum ownership: an owner that keeps requesting holds the display for exactly `HOLD_CYCLES` cycles, counting from its `o_switch` cycle, before preemption is possible.
  - With a competitor waiting, the new owner appears in cycle `HOLD_CYCLES`+1 relative to the first grant cycle.
- `o_grant` is always one-hot or zero. `o_valid` = OR of `o_grant`.

## Test plan
All scenarios use `NUM_REQ` = 4 and `HOLD_CYCLES` = 4.

- **Reset:** assert `i_reset` asynchronously mid-ownership (owner 2).
  - Outputs go to 0 without a clock edge.
  - After release with `i_req` = 0001, grant 0001 in the next cycle, `o_switch` = 1.
- **Single requester:** `i_req` = 0100, `i_data[23:16]` = 0x42.
  - One cycle later: `o_grant` = 0100, `o_value` = 0x42.
  - Change data to 0x43: `o_value` = 0x43 one cycle later.
  - Grant is held indefinitely with no extra `o_switch`.
- **Hold protection:**
  - Owner 0 granted at cycle t; `i_req[1]` rises at t+1.
  - Grant stays 0001 through t+3 and moves to 0010 at t+4, with `o_switch` = 1.
- **Round-robin:** `i_req` = 1111 continuously from reset.
  - Owners rotate 0→1→2→3→0, each for exactly 4 cycles.
  - `o_switch` pulses every 4 cycles.
- **Early release:** owner 1 drops `i_req` at hold cycle 2 while `i_req[3]` = 1.
  - Next cycle: `o_grant` = 1000, `o_valid` stays 1.
  - If no other request: `o_valid` = 0, `o_value` = 0x00.
- **Simultaneous events:** with `ptr` = 3 after owner 2's release coincides with expiry, `i_req` = 0011 from IDLE.
  - Grant 0001 (wrap-around search from `ptr` = 3 reaches index 0 first).
  - Then 0010 after 4 cycles.
